// File: rtl/loopback.sv
// loopback: UART 8N1 command/response endpoint (receiver, one-byte command parser, transmitter).
// Latency: a reply frame's start bit begins 2 clk after the ',' byte is accepted when tx is idle.
// Backpressure: rx never stalls; replies wait in a small tx queue and are dropped when it is full.
//
// Ports: clk (system clock), rst (synchronous, active-high), rx (serial in, idle high,
//        asynchronous to clk), tx (serial out, idle high).
// Build option: LOOPBACK_ECHO_EN -- echo every accepted byte ahead of any reply, with a
//        3-entry tx queue; when undefined only replies are sent, through a 1-entry buffer.

// loopback_fifo: small circular queue holding bytes waiting for the transmitter.
// Latency: a pushed entry is visible on dout the cycle after the push.
// Backpressure: pushes into a full queue are dropped unless a pop frees a slot in the same cycle.
module loopback_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // Storage is sized to the pointer range so any pointer value is a legal index.
  logic [W-1:0]  mem [2**PW];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, do_wr, do_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || do_rd);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end
endmodule

module loopback #(
  parameter int         CLOCK_FREQUENCY = 50_000_000,
  parameter int         BAUD_RATE       = 115200,
  parameter logic [7:0] TEST_RESPONSE   = 8'h08,
  parameter logic [7:0] VERSION         = 8'h01
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx
);
  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] COMMA = 8'h2C;
`ifdef LOOPBACK_ECHO_EN
  localparam int TXQ_DEPTH = 3;
`else
  localparam int TXQ_DEPTH = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // rx synchronizer, preset to the idle level so reset never looks like a start bit.
  logic rx_meta, rx_sync;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // ---------------- receiver ----------------
  uart_state_t      rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             rx_vld, rx_vld_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_vld   <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_vld   <= rx_vld_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_vld_n   = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_sync) rx_state_n = S_START;
      end
      S_START: if (rx_cnt == HALF_END) begin
        // Mid-start re-check; later samples then land mid-bit.
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_sync ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt == BIT_END) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_sync, rx_shift[7:1]};
        rx_bit_n   = rx_bit + 1'b1;
        if (rx_bit == 3'd7) rx_state_n = S_STOP;
      end
      S_STOP: if (rx_cnt == BIT_END) begin
        rx_cnt_n   = '0;
        rx_vld_n   = rx_sync;  // low stop bit: framing error, byte dropped
        rx_state_n = S_IDLE;
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  // ---------------- command parser ----------------
  logic [7:0] cmd, reply;
  logic       cmd_vld, reply_fire;

  assign reply_fire = rx_vld && (rx_shift == COMMA) && cmd_vld;

  always_comb begin
    reply = 8'h3F;
    case (cmd)
      8'h54: reply = TEST_RESPONSE;
      8'h56: reply = VERSION;
      default: reply = 8'h3F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd     <= '0;
      cmd_vld <= 1'b0;
    end else if (rx_vld) begin
      if (rx_shift != COMMA) begin
        cmd     <= rx_shift;
        cmd_vld <= 1'b1;
      end else begin
        cmd_vld <= 1'b0;
      end
    end
  end

  // ---------------- tx queue ----------------
  logic       q_push, q_pop, q_empty;
  logic [7:0] q_din, q_dout;

`ifdef LOOPBACK_ECHO_EN
  // The reply is pushed one cycle after the ',' echo so it queues behind it.
  logic       reply_pend;
  logic [7:0] reply_hold;
  always_ff @(posedge clk) begin
    if (rst) begin
      reply_pend <= 1'b0;
      reply_hold <= '0;
    end else begin
      reply_pend <= reply_fire;
      if (reply_fire) reply_hold <= reply;
    end
  end
  assign q_push = rx_vld || reply_pend;
  assign q_din  = rx_vld ? rx_shift : reply_hold;
`else
  assign q_push = reply_fire;
  assign q_din  = reply;
`endif

  loopback_fifo #(.W(8), .DEPTH(TXQ_DEPTH)) u_txq (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .dout  (q_dout),
    .empty (q_empty)
  );

  // ---------------- transmitter ----------------
  uart_state_t      tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]       tx_bit, tx_bit_n;
  logic [7:0]       tx_shift, tx_shift_n;
  logic             tx_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_n       = tx;
    q_pop      = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_n = '0;
        tx_n     = 1'b1;
        if (!q_empty) begin
          q_pop      = 1'b1;
          tx_shift_n = q_dout;
          tx_n       = 1'b0;
          tx_state_n = S_START;
        end
      end
      S_START: if (tx_cnt == BIT_END) begin
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
        tx_n       = tx_shift[0];
        tx_shift_n = {1'b0, tx_shift[7:1]};
        tx_state_n = S_DATA;
      end
      S_DATA: if (tx_cnt == BIT_END) begin
        tx_cnt_n = '0;
        if (tx_bit == 3'd7) begin
          tx_n       = 1'b1;
          tx_state_n = S_STOP;
        end else begin
          tx_n       = tx_shift[0];
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 1'b1;
        end
      end
      S_STOP: if (tx_cnt == BIT_END) begin
        tx_cnt_n = '0;
        // A queued byte starts straight after the stop bit, with no idle gap.
        if (!q_empty) begin
          q_pop      = 1'b1;
          tx_shift_n = q_dout;
          tx_n       = 1'b0;
          tx_state_n = S_START;
        end else begin
          tx_n       = 1'b1;
          tx_state_n = S_IDLE;
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_loopback.sv
// tb_loopback: drives 8N1 frames into loopback and decodes tx frames against a byte-level model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_loopback;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam logic [7:0] T_RESP = 8'h08;
  localparam logic [7:0] VER    = 8'h01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  loopback #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .BAUD_RATE       (BAUD),
    .TEST_RESPONSE   (T_RESP),
    .VERSION         (VER)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // Byte-level model: expected tx frames in order.
  logic [7:0] exp_q[$];
  int         exp_pushed  = 0;
  int         frames_seen = 0;
  logic [7:0] last_frame  = 8'h00;
  int         last_fall   = -1;
  int         stop_cycle  = 0;
  int         rst_epoch   = 0;
  bit         decoding    = 1'b0;
  logic [7:0] m_cmd       = 8'h00;
  bit         m_cv        = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] reply_of(input logic [7:0] c);
    if (c == 8'h54) return T_RESP;
    if (c == 8'h56) return VER;
    return 8'h3F;
  endfunction

  task automatic model_byte(input logic [7:0] b);
`ifdef LOOPBACK_ECHO_EN
    exp_q.push_back(b);
    exp_pushed++;
`endif
    if (b != 8'h2C) begin
      m_cmd = b;
      m_cv  = 1'b1;
    end else if (m_cv) begin
      exp_q.push_back(reply_of(m_cmd));
      exp_pushed++;
      m_cv = 1'b0;
    end
  endtask

  // One 8N1 frame on rx; a bad frame has its stop bit low.
  task automatic send_byte(input logic [7:0] b, input bit good, input int gap_bits);
    logic [9:0] frame;
    frame = {good, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == 9) stop_cycle = cyc;
      rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    if (good) model_byte(b);
    repeat (gap_bits * CPB) @(negedge clk);
  endtask

  task automatic send_pair(input logic [7:0] c);
    send_byte(c, 1'b1, 1);
    send_byte(8'h2C, 1'b1, 1);
  endtask

  // Wait for every modelled frame, then a quiet window, then compare frame counts.
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || decoding) && n < 60 * CPB) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || decoding) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_drain: timeout with %0d frames outstanding, expected 0", name, exp_q.size());
    end
    repeat (12 * CPB) @(negedge clk);
    check({name, "_count"}, frames_seen, exp_pushed);
  endtask

  // tx must stay high for a long window (only replies are modelled to appear).
  task automatic quiet(input string name);
    int lows;
    lows = 0;
    repeat (25 * CPB) begin
      @(negedge clk);
      if (!tx) lows++;
    end
`ifndef LOOPBACK_ECHO_EN
    check({name, "_tx_low_cycles"}, lows, 0);
`endif
    wait_drain(name);
  endtask

  // Compare process: decode each tx frame at bit centres and check it against the model.
  initial begin
    logic       prev;
    logic [7:0] b;
    logic       stopb;
    int         ep;
    prev = 1'b1;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (prev && !tx && !rst) begin
        decoding  = 1'b1;
        ep        = rst_epoch;
        last_fall = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stopb    = tx;
        decoding = 1'b0;
        if (ep == rst_epoch) begin
          frames_seen++;
          last_frame = b;
          check("stop_bit", stopb, 1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got %02h, model expects no frame", b);
          end else begin
            check("frame", b, exp_q.pop_front());
          end
        end
      end
      prev = tx;
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    int n, lat, lows;
    logic [7:0] b;
    bit good;
    int gap, r;

    repeat (3) @(negedge clk);
    check("tx_in_reset", tx, 1);
    rst = 1'b0;
    lows = 0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    check("idle_after_reset_low_cycles", lows, 0);

    // "T," -> 0x08, and the reply begins promptly after the ',' stop bit.
    send_byte(8'h54, 1'b1, 0);
    send_byte(8'h2C, 1'b1, 0);
    n = 0;
    while (last_fall < stop_cycle && n < 3 * CPB) begin
      @(negedge clk);
      n++;
    end
    lat = last_fall - stop_cycle;
    check("reply_latency_ok", (last_fall >= stop_cycle && lat <= CPB + 4) ? 1 : 0, 1);
    wait_drain("t_cmd");
    check("t_reply_literal", last_frame, 8'h08);

    send_pair(8'h56);
    wait_drain("v_cmd");
    check("v_reply_literal", last_frame, 8'h01);

    send_pair(8'h51);
    wait_drain("q_cmd");
    check("q_reply_literal", last_frame, 8'h3F);

    send_byte(8'h2C, 1'b1, 1);
    quiet("comma_alone");
    send_byte(8'h54, 1'b1, 1);
    quiet("t_alone");

    send_byte(8'h41, 1'b1, 1);
    send_pair(8'h54);
    wait_drain("last_wins");
    check("last_wins_literal", last_frame, 8'h08);

    // Framing error drops the command, so the ',' has nothing to dispatch.
    send_byte(8'h54, 1'b0, 1);
    send_byte(8'h2C, 1'b1, 1);
    quiet("bad_stop");
    send_pair(8'h54);
    wait_drain("after_bad_stop");
    check("after_bad_stop_literal", last_frame, 8'h08);

    // Short low pulse on rx must be rejected as a start bit.
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    quiet("glitch");
    send_pair(8'h56);
    wait_drain("after_glitch");
    check("after_glitch_literal", last_frame, 8'h01);

    // Reset in the middle of an outgoing frame.
    send_pair(8'h54);
    n = 0;
    while (!decoding && n < 4 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_frame_started", decoding, 1);
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    rst_epoch++;
    exp_pushed = exp_pushed - exp_q.size();
    exp_q.delete();
    m_cv  = 1'b0;
    m_cmd = 8'h00;
    @(negedge clk);
    check("tx_after_mid_frame_rst", tx, 1);
    rst = 1'b0;
    lows = 0;
    repeat (15 * CPB) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    check("no_frame_after_rst_low_cycles", lows, 0);
    wait_drain("after_rst");
    send_pair(8'h54);
    wait_drain("post_rst");
    check("post_rst_literal", last_frame, 8'h08);

    // Randomized command stream against the model.
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 7);
      case (r)
        0, 7:    b = 8'h54;
        1:       b = 8'h56;
        2:       b = 8'h51;
        3:       b = 8'h41;
        4, 5:    b = 8'h2C;
        default: b = 8'($urandom_range(0, 255));
      endcase
      good = ($urandom_range(0, 9) != 0);
      gap  = $urandom_range(0, 2);
      if (!good && gap == 0) gap = 1;
`ifdef LOOPBACK_ECHO_EN
      if (b == 8'h2C) gap = gap + 11;
`endif
      send_byte(b, good, gap);
    end
    wait_drain("random");
    check("random_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
